add_seq_ctrl: RTL and testbench

ADD_SEQ_CTRL -- requirements
Module: add_seq_ctrl

---
 rtl/add_seq_ctrl.sv | 155 +++++++++++++++
 tb/tb_add_seq_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/add_seq_ctrl.sv
// Sequential W-bit adder: one shared N-bit gen_add slice processes the operands
// least-significant slice first, one slice per clock, with a one-cycle done pulse.

module gen_add #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] s,
  output logic         co
);
  logic [N:0] total;

  always_comb begin
    total = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, ci};
    s     = total[N-1:0];
    co    = total[N];
  end
endmodule

module add_seq_ctrl #(
  parameter int N     = 4,
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [N*WORDS-1:0]   a,
  input  logic [N*WORDS-1:0]   b,
  input  logic                 carry_in,
  output logic                 busy,
  output logic                 done,
  output logic [N*WORDS-1:0]   sum,
  output logic                 carry_out
);
  localparam int W  = N * WORDS;
  localparam int IW = $clog2(WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   sum_q, sum_d;
  logic           c_q, c_d;
  logic           cout_q, cout_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic [N-1:0]   add_a, add_b, add_s;
  logic           add_co;

  // Slice select for the shared adder, driven by the current slice index.
  always_comb begin
    add_a = '0;
    add_b = '0;
    for (int unsigned i = 0; i < WORDS; i++) begin
      if (idx_q == IW'(i)) begin
        add_a = a_q[i*N +: N];
        add_b = b_q[i*N +: N];
      end
    end
  end

  gen_add #(.N(N)) u_add (
    .a  (add_a),
    .b  (add_b),
    .ci (c_q),
    .s  (add_s),
    .co (add_co)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    c_d     = c_q;
    cout_d  = cout_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          c_d     = carry_in;
          sum_d   = '0;
          cout_d  = 1'b0;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int unsigned i = 0; i < WORDS; i++) begin
          if (idx_q == IW'(i)) begin
            sum_d[i*N +: N] = add_s;
          end
        end
        c_d = add_co;
        // idx parks on the last slice instead of wrapping; the next accept clears it.
        if (idx_q == IW'(WORDS - 1)) begin
          cout_d  = add_co;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign sum       = sum_q;
  assign carry_out = cout_q;
endmodule

// File: tb/tb_add_seq_ctrl.sv
// Randomized and directed checks of add_seq_ctrl against a cycle-level
// behavioural model built from whole-word arithmetic and a phase counter.

module tb_add_seq_ctrl;
  localparam int N     = 4;
  localparam int WORDS = 4;
  localparam int W     = N * WORDS;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         carry_in = 1'b0;
  logic         busy, done, carry_out;
  logic [W-1:0] sum;

  int cmp_cnt = 0;
  int err_cnt = 0;
  int done_seen = 0;

  add_seq_ctrl #(.N(N), .WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] low_mask(input int slices);
    logic [W-1:0] m;
    m = '0;
    for (int i = 0; i < slices * N; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Model: phase 0 = idle; phase p>=1 means p-1 slices are complete;
  // phase WORDS+1 is the done cycle, after which the model returns to idle.
  int           m_p = 0;
  logic [W:0]   m_full = '0;
  logic [W-1:0] m_sum = '0;
  logic         m_cout = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_p    = 0;
      m_full = '0;
      m_sum  = '0;
      m_cout = 1'b0;
    end else if (m_p == 0) begin
      if (start) begin
        m_full = {1'b0, a} + {1'b0, b} + (W+1)'(carry_in);
        m_p    = 1;
        m_sum  = '0;
        m_cout = 1'b0;
      end
    end else if (m_p == WORDS + 1) begin
      m_p = 0;
    end else begin
      m_p++;
      m_sum = m_full[W-1:0] & low_mask(m_p - 1);
      if (m_p == WORDS + 1) m_cout = m_full[W];
    end
  end

  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(m_p != 0));
    chk("done", 32'(done), 32'(m_p == WORDS + 1));
    chk("sum", 32'(sum), 32'(m_sum));
    chk("carry_out", 32'(carry_out), 32'(m_cout));
    if (done) done_seen++;
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 32'(busy), 32'(0));
  endtask

  // Accept one operation (DUT must be idle), scramble inputs, wait for done.
  task automatic run_op(input logic [W-1:0] aa, input logic [W-1:0] bb,
                        input logic cc, output int lat);
    wait_idle();
    a = aa; b = bb; carry_in = cc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); carry_in = 1'($urandom);
    lat = 1;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!done) chk("done_timeout", 32'(done), 32'(1));
  endtask

  initial begin
    int lat;
    int d0;
    logic [W-1:0] ra, rb;

    #1;
    chk("reset_busy", 32'(busy), 32'(0));
    chk("reset_done", 32'(done), 32'(0));
    chk("reset_sum", 32'(sum), 32'(0));
    chk("reset_cout", 32'(carry_out), 32'(0));

    // start held while reset is low must not be accepted
    start = 1'b1; a = 16'h0003; b = 16'h0004; carry_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("start_in_reset", 32'(busy), 32'(0));
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("first_accept", 32'(busy), 32'(1));
    start = 1'b0;
    wait_idle();
    chk("first_sum", 32'(sum), 32'h0007);

    run_op(16'h00FF, 16'h0001, 1'b0, lat);
    chk("lat_029", 32'(lat), 32'd5);
    chk("sum_029", 32'(sum), 32'h0100);
    chk("cout_029", 32'(carry_out), 32'(0));
    chk("model_029", 32'(m_sum), 32'h0100);

    run_op(16'hFFFF, 16'h0000, 1'b1, lat);
    chk("sum_030", 32'(sum), 32'h0000);
    chk("cout_030", 32'(carry_out), 32'(1));
    chk("model_cout_030", 32'(m_cout), 32'(1));

    // start held continuously, operands changed after the accept
    wait_idle();
    d0 = done_seen;
    a = 16'h0F0F; b = 16'h0101; carry_in = 1'b0; start = 1'b1;
    @(negedge clk);
    a = 16'hAAAA; b = 16'h1111;
    lat = 1;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("lat_031", 32'(lat), 32'd5);
    chk("sum_031a", 32'(sum), 32'h1010);
    @(negedge clk);
    chk("gap_031", 32'(busy), 32'(0));
    @(negedge clk);
    chk("reaccept_031", 32'(busy), 32'(1));
    start = 1'b0;
    wait_idle();
    chk("sum_031b", 32'(sum), 32'hBBBB);
    chk("dones_031", 32'(done_seen - d0), 32'd2);

    // reset mid-RUN after two RUN edges
    wait_idle();
    d0 = done_seen;
    a = 16'h1234; b = 16'h4321; carry_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("partial_032", 32'(sum), 32'h0055);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_sum", 32'(sum), 32'(0));
    chk("abort_cout", 32'(carry_out), 32'(0));
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("no_done_032", 32'(done_seen - d0), 32'd0);
    run_op(16'h1234, 16'h4321, 1'b0, lat);
    chk("sum_032", 32'(sum), 32'h5555);

    // 8000+8000: sum stays zero throughout RUN and holds afterwards
    wait_idle();
    a = 16'h8000; b = 16'h8000; carry_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < WORDS; i++) begin
      chk("run_zero_033", 32'(sum), 32'h0000);
      @(negedge clk);
    end
    chk("done_033", 32'(done), 32'(1));
    chk("cout_033", 32'(carry_out), 32'(1));
    repeat (3) @(negedge clk);
    chk("hold_sum_033", 32'(sum), 32'h0000);
    chk("hold_cout_033", 32'(carry_out), 32'(1));

    // randomized traffic with occasional asynchronous resets
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) == 0);
      ra = ($urandom_range(0, 3) == 0) ? '1 : W'($urandom);
      rb = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
      a = ra; b = rb; carry_in = 1'($urandom);
      if ($urandom_range(0, 70) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
      end
    end
    start = 1'b0;
    repeat (8) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule
